// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the multi-channel tick scheduler.
package tick_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam int PRE_DEF = 50;
  localparam int PW_DEF  = 25;

  // Prescaler counter width; never narrower than one bit.
  function automatic int pre_w(input int pre);
    return (pre <= 2) ? 1 : $clog2(pre);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One divider channel: counts base ticks, emits a one-cycle tick and a toggling wave.
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          base_i,
  input  logic          apply_i,
  input  logic [PW-1:0] period_i,
  input  logic          en_i,
  output logic          tick_o,
  output logic          wave_o,
  output logic          en_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic          en_q, en_d;
  logic          wave_q, wave_d;
  logic          tick_q, tick_d;

  // Apply wins over counting so the reconfigured channel restarts cleanly from 0.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    en_d     = en_q;
    wave_d   = wave_q;
    tick_d   = 1'b0;
    if (apply_i) begin
      period_d = period_i;
      en_d     = en_i;
      cnt_d    = '0;
      if (!en_i) wave_d = 1'b0;
    end else if (base_i && en_q) begin
      if (cnt_q == period_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      period_q <= '0;
      en_q     <= 1'b0;
      wave_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      en_q     <= en_d;
      wave_q   <= wave_d;
      tick_q   <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign wave_o = wave_q;
  assign en_o   = en_q;

endmodule

// File: rtl/tick_sched.sv
// Shared prescaler plus config sequencer driving NCH tick_chan instances.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = PW_DEF,
  parameter int PRE = PRE_DEF,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_en,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] wave,
  output logic [NCH-1:0] ch_en
);

  localparam int PCW = pre_w(PRE);

  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           base;
  state_e         state_q, state_d;
  logic [CW-1:0]  lat_ch_q, lat_ch_d;
  logic [PW-1:0]  lat_period_q, lat_period_d;
  logic           lat_en_q, lat_en_d;
  logic           apply;

  assign base = (pcnt_q == PCW'(PRE - 1));

  // Prescaler wraps at PRE-1; base marks the last cycle of each period.
  always_comb begin
    pcnt_d = base ? '0 : pcnt_q + 1'b1;
  end

  // Config sequencer: accept in IDLE, hold one pending config until the next base edge.
  always_comb begin
    state_d      = state_q;
    lat_ch_d     = lat_ch_q;
    lat_period_d = lat_period_q;
    lat_en_d     = lat_en_q;
    cfg_ready    = 1'b0;
    apply        = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          lat_ch_d     = cfg_ch;
          lat_period_d = cfg_period;
          lat_en_d     = cfg_en;
          state_d      = PEND;
        end
      end
      PEND: begin
        if (base) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler and sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q       <= '0;
      state_q      <= IDLE;
      lat_ch_q     <= '0;
      lat_period_q <= '0;
      lat_en_q     <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      state_q      <= state_d;
      lat_ch_q     <= lat_ch_d;
      lat_period_q <= lat_period_d;
      lat_en_q     <= lat_en_d;
    end
  end

  // Out-of-range channel indices match no instance, so the config is dropped.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tick_chan #(.PW(PW)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .base_i   (base),
      .apply_i  (apply && (lat_ch_q == CW'(c))),
      .period_i (lat_period_q),
      .en_i     (lat_en_q),
      .tick_o   (tick[c]),
      .wave_o   (wave[c]),
      .en_o     (ch_en[c])
    );
  end

endmodule

// File: tb/tb_tick_sched.sv
// Randomized and directed bench for tick_sched against an arithmetic reference model.
module tb_tick_sched;
  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int PRE = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic           cfg_en = 1'b0;
  logic [NCH-1:0] tick, wave, ch_en;

  tick_sched #(.NCH(NCH), .PW(PW), .PRE(PRE), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en),
    .tick(tick), .wave(wave), .ch_en(ch_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Reference model: edge index since reset, per-channel apply base index and period.
  int e;
  int m_en[NCH], m_p[NCH], m_ab[NCH], m_w[NCH];
  logic [NCH-1:0] m_tick;
  int m_pend, m_lch, m_lp, m_len;
  int en_rise_e[NCH];
  logic [NCH-1:0] en_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0; m_pend = 0; m_lch = 0; m_lp = 0; m_len = 0; m_tick = '0;
    en_prev = '0;
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_p[c] = 0; m_ab[c] = 0; m_w[c] = 0; en_rise_e[c] = -1;
    end
  endtask

  task automatic model_edge();
    bit base, app, acc;
    int bidx;
    base = ((e % PRE) == PRE - 1);
    bidx = e / PRE;
    app  = (m_pend != 0) && base;
    acc  = cfg_valid && (m_pend == 0);
    m_tick = '0;
    for (int c = 0; c < NCH; c++) begin
      if (base && m_en[c] != 0 && !(app && m_lch == c) &&
          ((bidx - m_ab[c]) % (m_p[c] + 1) == 0)) begin
        m_tick[c] = 1'b1;
        m_w[c] = m_w[c] ^ 1;
      end
    end
    if (app) begin
      if (m_lch < NCH) begin
        m_en[m_lch] = m_len; m_p[m_lch] = m_lp; m_ab[m_lch] = bidx;
        if (m_len == 0) m_w[m_lch] = 0;
      end
      m_pend = 0;
    end
    if (acc) begin
      m_pend = 1; m_lch = int'(cfg_ch); m_lp = int'(cfg_period); m_len = int'(cfg_en);
    end
  endtask

  function automatic logic [NCH-1:0] m_vec_w();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (m_w[c] != 0);
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_vec_en();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (m_en[c] != 0);
    return v;
  endfunction

  // Called at a negedge: compare, advance model through the next posedge, wait.
  task automatic step();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("wave", 32'(wave), 32'(m_vec_w()));
    chk("ch_en", 32'(ch_en), 32'(m_vec_en()));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
    for (int c = 0; c < NCH; c++)
      if (ch_en[c] && !en_prev[c]) en_rise_e[c] = e - 1;
    en_prev = ch_en;
    model_edge();
    e++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a config and step until it is accepted; cfg_valid is left high.
  task automatic send(input int ch, input int p, input int en);
    bit acc;
    cfg_ch = CW'(ch); cfg_period = PW'(p); cfg_en = en[0]; cfg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = (m_pend == 0);
      step();
      if (acc) return;
    end
    chk("accept_timeout", 1, 0);
  endtask

  task automatic wait_tick(input int c, output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tick[c]) begin
        edge_idx = e - 1;
        return;
      end
    end
    chk("tick_timeout", 1, 0);
  endtask

  initial begin
    int t1, t2, n;
    model_reset();
    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wave", 32'(wave), 0);
    chk("rst_en", 32'(ch_en), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    reset = 1'b1;
    repeat (40) step();

    // 2. basic channel
    send(0, 2, 1);
    cfg_valid = 1'b0;
    chk("pend_ready", 32'(cfg_ready), 0);
    wait_tick(0, t1);
    chk("ch0_first", 32'(t1 - en_rise_e[0]), 12);
    wait_tick(0, t2);
    chk("ch0_spacing", 32'(t2 - t1), 12);

    // 3. fastest rate alongside ch0
    send(1, 0, 1);
    cfg_valid = 1'b0;
    wait_tick(0, t1);
    wait_tick(0, t2);
    chk("ch0_spacing2", 32'(t2 - t1), 12);
    wait_tick(1, t1);
    wait_tick(1, t2);
    chk("ch1_spacing", 32'(t2 - t1), 4);

    // 4. back-to-back configs with cfg_valid held
    send(2, 1, 1);
    send(3, 3, 1);
    cfg_valid = 1'b0;
    repeat (10) step();
    chk("b2b_gap", 32'(en_rise_e[3] - en_rise_e[2]), 4);

    // 5. disable ch0 while its wave is high
    for (int i = 0; i < 40 && m_w[0] == 0; i++) step();
    chk("wave0_high", 32'(wave[0]), 1);
    send(0, 2, 0);
    cfg_valid = 1'b0;
    repeat (5) step();
    chk("dis_wave0", 32'(wave[0]), 0);
    chk("dis_en0", 32'(ch_en[0]), 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tick[0]) n++;
    end
    chk("dis_no_tick", 32'(n), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cfg_valid  = ($urandom % 3 == 0);
      cfg_ch     = CW'($urandom % NCH);
      cfg_period = PW'($urandom % 6);
      cfg_en     = ($urandom % 4 != 0);
      step();
    end
    cfg_valid = 1'b0;
    repeat (8) step();

    // 6. async reset while a config is pending
    send(2, 5, 1);
    cfg_valid = 1'b0;
    step();
    #1 reset = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_wave", 32'(wave), 0);
    chk("arst_en", 32'(ch_en), 0);
    chk("arst_ready", 32'(cfg_ready), 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) step();
    chk("arst_discard", 32'(ch_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Multi-channel tick scheduler. One shared prescaler serves NCH independent, runtime-programmable divider channels.
- Replaces per-consumer fixed clock dividers. Produces single-cycle clock enables (tick) plus 50%-duty toggle outputs (wave) for the spike-driver and display logic.
- All logic runs in the clk domain. No derived clocks are used as clocks.
- Reconfiguration uses a valid/ready handshake. Updates are applied only on a prescaler boundary, so an update never produces a runt pulse.

Parameters:
- NCH, 4: number of channels (2..8).
- PW, 25: width of the per-channel period register and counter.
- PRE, 50: base prescaler divisor, in clk cycles per base tick (>=2).
- CW, 2: channel-index width; must satisfy 2^CW >= NCH.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config request
- cfg_ready  out  1  scheduler can accept a config
- cfg_ch  in  CW  target channel
- cfg_period  in  PW  compare value P
- cfg_en  in  1  channel enable
- tick  out  NCH  one-cycle enable pulse per channel
- wave  out  NCH  toggled square output per channel
- ch_en  out  NCH  current enable state per channel

Behaviour:
- Reset (reset=0, async):
  - prescaler=0, all channel counters=0, periods=0, ch_en=0, tick=0, wave=0.
  - FSM goes to IDLE, cfg_ready=1, pending config cleared.
- Prescaler:
  - pcnt counts 0..PRE-1 and wraps to 0.
  - base = (pcnt==PRE-1), combinational and internal.
- Channel c on a clk edge with base=1 and ch_en[c]=1:
  - if cnt[c]==period[c]: cnt<=0, tick[c]<=1, wave[c]<=~wave[c].
  - else: cnt<=cnt+1.
- Channel c on any other edge: tick[c]<=0; cnt and wave hold.
- Resulting timing: tick period = (P+1)*PRE clk; wave period = 2*(P+1)*PRE clk.
  - P=0 ticks on every base tick.
  - tick is registered: high for exactly one clk, starting the cycle after the base edge.
- Config FSM:
  - IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch ch/period/en and go to PEND.
  - PEND: cfg_ready=0. On the edge where base=1, apply the latched config and return to IDLE.
  - Apply actions: period[ch]<=latched period, ch_en[ch]<=en, cnt[ch]<=0, tick[ch]<=0. If en=0, also wave[ch]<=0.
  - The target channel does not count on its apply edge. Other channels count normally on that same edge.
  - If the accept and base coincide in IDLE, apply happens at the NEXT base, not the current one.
- Apply-to-first-tick: first tick comes (P+1) base ticks after the apply edge.
- Re-enabling or rewriting an enabled channel restarts its phase from cnt=0. wave keeps its level unless the channel is disabled.
- Back-to-back requests: a held cfg_valid is accepted on the first IDLE cycle after apply. There is at most one pending config.
- cfg_ch >= NCH: the request is accepted and sequenced through PEND, but applies to no channel.
- Counter compare is equality only. If period is rewritten while the channel is disabled, the restart to 0 on apply guarantees no wrap past 2^PW.
- Reset mid-PEND: the pending config is discarded and all channels return to the reset state.

Decomposition:
- Shared package tick_sched_pkg:
  - FSM state enum (IDLE, PEND).
  - Default constants PRE_DEF, PW_DEF.
  - Prescaler width function: clog2(PRE).
- One natural sub-module: tick_chan. It holds one channel's cnt/period/en/wave/tick registers and takes base, apply and cfg inputs. It is instantiated NCH times in a generate loop.
- Prescaler and FSM stay in the top level.

Test Plan (PRE=4, NCH=4, PW=8):
1. Reset:
   - Stimulus: hold reset=0 for 3 clk, then release.
   - Response: tick=0, wave=0, ch_en=0, cfg_ready=1. All outputs stay 0 for 40 clk with no config.
2. Basic channel:
   - Stimulus: config ch0 P=2 en=1.
   - Response: cfg_ready low until the next base edge. First tick[0] pulse comes 12 clk after the apply edge, then every 12 clk, one cycle wide. wave[0] toggles on each tick (24-clk period).
3. Fastest rate:
   - Stimulus: config ch1 P=0 en=1 while ch0 runs.
   - Response: tick[1] every 4 clk. The ch0 tick spacing stays exactly 12 clk across the ch1 apply.
4. Back-to-back configs:
   - Stimulus: hold cfg_valid for ch2 P=1, then ch3 P=3.
   - Response: the second request is accepted the cycle after the first apply. ch3's apply lands one base tick (4 clk) after ch2's apply.
5. Disable mid-run:
   - Stimulus: while wave[0]=1, config ch0 en=0.
   - Response: on the apply edge wave[0]=0 and ch_en[0]=0. No further tick[0]. Other channels are unaffected.
6. Async reset during PEND:
   - Stimulus: pull reset low one clk after a config is accepted.
   - Response: all outputs clear immediately. After release, cfg_ready=1 and the discarded config never takes effect (ch_en stays 0).
